dmem_bus_bridge: RTL and testbench

//  Data-memory stage downstream of the single-cycle ARM datapath. Turns the core's
//  one-cycle load/store request into a req/ack transaction on a slow memory bus,

---
 rtl/dmem_bus_bridge_if.sv | 29 ++
 rtl/dmem_bus_bridge.sv | 125 ++++++++++++
 tb/tb_dmem_bus_bridge.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_bridge_if.sv
// dmem_bus_bridge_if
//   Memory-bus side of the data-memory bridge. The bridge is the master and
//   the memory is the slave.
//   BusReq    master->slave  request, held until BusAck or abort
//   BusWe     master->slave  1 = write, 0 = read
//   BusAddr   master->slave  word-aligned byte address
//   BusWData  master->slave  write data
//   BusAck    slave->master  single-cycle completion pulse
//   BusRData  slave->master  read data, valid in the BusAck cycle
interface dmem_bus_bridge_if #(
  parameter int unsigned DATA_W = 32
);
  logic              BusReq;
  logic              BusWe;
  logic [DATA_W-1:0] BusAddr;
  logic [DATA_W-1:0] BusWData;
  logic              BusAck;
  logic [DATA_W-1:0] BusRData;

  modport master (
    output BusReq, BusWe, BusAddr, BusWData,
    input  BusAck, BusRData
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusWData,
    output BusAck, BusRData
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge
//   Data-memory stage behind a single-cycle core. A one-cycle load/store
//   request becomes a req/ack transaction on a slow bus; the core is stalled
//   until the bus completes. Load data and a sticky fault flag are returned.
// Ports
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   MemRead, MemWrite    core load / store request (both high = store)
//   Addr, WriteData      core byte address and store data
//   ReadData             load data, valid in the DONE cycle, held otherwise
//   Stall                core must hold PC and register writes while high
//   Fault                sticky: timeout or misaligned access seen
//   bus                  master side of the memory bus (dmem_bus_bridge_if)
module dmem_bus_bridge #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              Fault,
  dmem_bus_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (MemRead || MemWrite) begin
          if (Addr[1:0] == 2'b00) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = Addr;
            wdata_d = WriteData;
          end else begin
            // Misaligned: complete without touching the bus.
            state_d = DONE;
            fault_d = 1'b1;
            rdata_d = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack is tested first so it wins over a simultaneous timeout.
        if (bus.BusAck) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = bus.BusRData;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          fault_d = 1'b1;
          if (!we_q) rdata_d = ERR_DATA;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Stall        = ((state_q == IDLE) && (MemRead || MemWrite)) || (state_q == REQ);
  assign ReadData     = rdata_q;
  assign Fault        = fault_q;
  assign bus.BusReq   = req_q;
  assign bus.BusWe    = we_q;
  assign bus.BusAddr  = addr_q;
  assign bus.BusWData = wdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Testbench for dmem_bus_bridge: directed accesses, a transaction-level
// model of the expected per-cycle outputs, one negedge compare process and
// hand-computed literal expectations per access.
module tb_dmem_bus_bridge;
  localparam int unsigned DW  = 32;
  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] Addr = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall, Fault;

  dmem_bus_bridge_if #(.DATA_W(DW)) bus();

  dmem_bus_bridge #(.DATA_W(DW), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .Fault(Fault), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state and per-cycle expectations.
  logic        m_fault = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        chk_en = 1'b0;
  logic        e_stall = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("Stall", 32'(Stall), 32'(e_stall));
      check("BusReq", 32'(bus.BusReq), 32'(e_req));
      check("Fault", 32'(Fault), 32'(m_fault));
      check("ReadData", ReadData, m_rdata);
      if (e_req) begin
        check("BusWe", 32'(bus.BusWe), 32'(e_we));
        check("BusAddr", bus.BusAddr, e_addr);
        check("BusWData", bus.BusWData, e_wdata);
      end
    end
  end

  // One access from the core. ack_at: REQ cycle index (0-based) of the ack,
  // negative = never. stray: extra BusAck pulses in the IDLE and DONE cycles.
  task automatic access(input string nm, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdat, input logic stray,
                        input int lit_stall, input int lit_req,
                        input logic [31:0] lit_rdata, input logic lit_fault);
    bit          aligned, acked;
    int          n_req, seen_stall, seen_req;
    logic [31:0] nxt_rdata, done_rdata;
    logic        nxt_fault;
    aligned    = (a[1:0] == 2'b00);
    acked      = aligned && (ack_at >= 0) && (ack_at < int'(TO));
    n_req      = !aligned ? 0 : (acked ? ack_at + 1 : int'(TO));
    nxt_rdata  = !aligned ? 32'h0 : (wr ? m_rdata : (acked ? rdat : ERR));
    nxt_fault  = m_fault | !aligned | (aligned & !acked);
    seen_stall = 0;
    seen_req   = 0;
    done_rdata = '0;
    for (int k = 0; k <= n_req + 1; k++) begin
      @(posedge clk);
      #1;
      MemRead      = rd;
      MemWrite     = wr;
      Addr         = a;
      WriteData    = wd;
      bus.BusAck   = (acked && k == ack_at + 1) || (stray && (k == 0 || k == n_req + 1));
      bus.BusRData = (acked && k == ack_at + 1) ? rdat : $urandom;
      e_stall      = (k <= n_req);
      e_req        = (k >= 1) && (k <= n_req);
      e_we         = wr;
      e_addr       = a;
      e_wdata      = wd;
      if (k == n_req + 1) begin
        m_rdata = nxt_rdata;
        m_fault = nxt_fault;
      end
      chk_en = 1'b1;
      @(negedge clk);
      if (Stall) seen_stall++;
      if (bus.BusReq) seen_req++;
      if (k == n_req + 1) done_rdata = ReadData;
    end
    check({nm, " stall cycles"}, seen_stall, lit_stall);
    check({nm, " req cycles"}, seen_req, lit_req);
    check({nm, " ReadData in DONE"}, done_rdata, lit_rdata);
    check({nm, " Fault"}, 32'(Fault), 32'(lit_fault));
  endtask

  task automatic idle(input int n, input logic stray);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      bus.BusAck   = stray;
      bus.BusRData = $urandom;
      e_stall      = 1'b0;
      e_req        = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.BusAck   = 1'b0;
    bus.BusRData = '0;
    #2;
    check("reset Stall", 32'(Stall), 32'h0);
    check("reset BusReq", 32'(bus.BusReq), 32'h0);
    check("reset BusWe", 32'(bus.BusWe), 32'h0);
    check("reset BusAddr", bus.BusAddr, 32'h0);
    check("reset BusWData", bus.BusWData, 32'h0);
    check("reset ReadData", ReadData, 32'h0);
    check("reset Fault", 32'(Fault), 32'h0);
    #10 reset = 1'b0;

    idle(2, 1'b0);
    // T1 store, ack in first REQ cycle
    access("T1", 1'b0, 1'b1, 32'h100, 32'h12345678, 0, 32'h0, 1'b0, 2, 1, 32'h0, 1'b0);
    // T2 load, 3 wait cycles; ack coincides with the timeout cycle and wins
    access("T2", 1'b1, 1'b0, 32'h200, 32'h0, 3, 32'hCAFEF00D, 1'b0, 5, 4, 32'hCAFEF00D, 1'b0);
    access("T2b", 1'b1, 1'b0, 32'h204, 32'h0, 1, 32'h11223344, 1'b0, 3, 2, 32'h11223344, 1'b0);
    idle(1, 1'b0);
    // T4 misaligned load
    access("T4", 1'b1, 1'b0, 32'h203, 32'h0, 0, 32'h55555555, 1'b0, 1, 0, 32'h0, 1'b1);

    // T5 reset mid-REQ
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      MemRead    = 1'b1;
      MemWrite   = 1'b0;
      Addr       = 32'h300;
      bus.BusAck = 1'b0;
      e_stall    = 1'b1;
      e_req      = (k >= 1);
      e_we       = 1'b0;
      e_addr     = 32'h300;
      e_wdata    = WriteData;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("T5 BusReq before reset", 32'(bus.BusReq), 32'h1);
    chk_en  = 1'b0;
    MemRead = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("T5 BusReq async", 32'(bus.BusReq), 32'h0);
    check("T5 Stall async", 32'(Stall), 32'h0);
    check("T5 Fault async", 32'(Fault), 32'h0);
    m_fault = 1'b0;
    m_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    access("T5 next", 1'b1, 1'b0, 32'h304, 32'h0, 1, 32'h0BADF00D, 1'b0, 3, 2, 32'h0BADF00D, 1'b0);

    // T6 back-to-back loads with stray acks in IDLE/DONE
    access("T6a", 1'b1, 1'b0, 32'h400, 32'h0, 0, 32'hA5A5A5A5, 1'b1, 2, 1, 32'hA5A5A5A5, 1'b0);
    access("T6b", 1'b1, 1'b0, 32'h404, 32'h0, 0, 32'h5A5A5A5A, 1'b1, 2, 1, 32'h5A5A5A5A, 1'b0);
    idle(2, 1'b1);

    // T3 load timeout, then a timed-out store keeps ReadData, fault stays set
    access("T3", 1'b1, 1'b0, 32'h500, 32'h0, -1, 32'h0, 1'b0, 5, 4, 32'hDEADBEEF, 1'b1);
    access("T3 store", 1'b0, 1'b1, 32'h504, 32'h77, -1, 32'h0, 1'b0, 5, 4, 32'hDEADBEEF, 1'b1);
    access("T3 after", 1'b1, 1'b0, 32'h508, 32'h0, 0, 32'h13579BDF, 1'b0, 2, 1, 32'h13579BDF, 1'b1);
    // read+write together is a store
    access("RW", 1'b1, 1'b1, 32'h600, 32'h99, 0, 32'hFFFF0000, 1'b0, 2, 1, 32'h13579BDF, 1'b1);
    idle(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
